// File: rtl/adc_capture_if.sv
// adc_capture_if: ADC sample input and FIFO write port bundle for adc_capture
// Ports: adc_data/adc_valid (ADC stream), fifo_full (FIFO status),
//        wr_en/wr_data (FIFO write). master = capture block, slave = its environment.
interface adc_capture_if #(
    parameter int ADC_WIDTH = 14
);
    logic [ADC_WIDTH-1:0] adc_data;
    logic                 adc_valid;
    logic                 fifo_full;
    logic                 wr_en;
    logic [ADC_WIDTH-1:0] wr_data;

    modport master (input adc_data, adc_valid, fifo_full, output wr_en, wr_data);
    modport slave (output adc_data, adc_valid, fifo_full, input wr_en, wr_data);
endinterface

// File: rtl/adc_capture.sv
// adc_capture: settle, block-average and write ADC samples into the sample FIFO
// Ports: clk, rst_n (async active-low), enable (capture level), clr_stat (clear stats pulse),
//        bus (adc_data/adc_valid/fifo_full in, wr_en/wr_data out),
//        busy (SETTLE or ACCUM), overflow (sticky drop flag), drop_cnt (saturating drop count).
module adc_capture #(
    parameter int ADC_WIDTH      = 14,
    parameter int DECIM_LOG2     = 2,
    parameter int SETTLE_SAMPLES = 8,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 clr_stat,
    adc_capture_if.master        bus,
    output logic                 busy,
    output logic                 overflow,
    output logic [CNT_WIDTH-1:0] drop_cnt
);
    localparam int AW = ADC_WIDTH + DECIM_LOG2;
    localparam int CW = DECIM_LOG2 > 0 ? DECIM_LOG2 : 1;
    localparam int SW = $clog2(SETTLE_SAMPLES + 2);

    typedef enum logic [1:0] {IDLE, SETTLE, ACCUM} state_t;

    state_t        state;
    logic [AW-1:0] acc;
    logic [AW-1:0] acc_next;
    logic [CW-1:0] sample_cnt;
    logic [SW-1:0] settle_cnt;
    logic          done;

    assign acc_next = acc + AW'(bus.adc_data);
    // The block completes on the sample that fills it, even if enable falls in that cycle.
    assign done = state == ACCUM && bus.adc_valid && sample_cnt == CW'((1 << DECIM_LOG2) - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            acc         <= '0;
            sample_cnt  <= '0;
            settle_cnt  <= '0;
            busy        <= 1'b0;
            overflow    <= 1'b0;
            drop_cnt    <= '0;
            bus.wr_en   <= 1'b0;
            bus.wr_data <= '0;
        end else begin
            bus.wr_en <= 1'b0;
            // enable alone decides whether the next state is IDLE
            busy <= enable;
            if (clr_stat) begin
                overflow <= 1'b0;
                drop_cnt <= '0;
            end
            if (done && bus.fifo_full) begin
                overflow <= 1'b1;
                drop_cnt <= clr_stat ? CNT_WIDTH'(1) : drop_cnt + CNT_WIDTH'(drop_cnt != '1);
            end else if (done) begin
                bus.wr_en   <= 1'b1;
                bus.wr_data <= acc_next[AW-1:DECIM_LOG2];
            end
            if (!enable) begin
                state      <= IDLE;
                acc        <= '0;
                sample_cnt <= '0;
                settle_cnt <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        state      <= SETTLE_SAMPLES == 0 ? ACCUM : SETTLE;
                        settle_cnt <= '0;
                    end
                    SETTLE: if (bus.adc_valid) begin
                        state      <= settle_cnt == SW'(SETTLE_SAMPLES - 1) ? ACCUM : SETTLE;
                        settle_cnt <= settle_cnt + SW'(1);
                    end
                    ACCUM: if (bus.adc_valid) begin
                        acc        <= done ? '0 : acc_next;
                        sample_cnt <= done ? '0 : sample_cnt + CW'(1);
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_adc_capture.sv
// tb_adc_capture: directed checks of averaging, flow control, statistics, abort and pass-through
module tb_adc_capture;
    logic        clk = 1'b0;
    logic        rst_a, rst_p, en_a, en_p, clr_a, clr_p;
    logic        busy_a, busy_p, ov_a, ov_p;
    logic [15:0] dc_a, dc_p;
    int          checks = 0;
    int          errors = 0;
    int          wr_seen;

    always #5 clk = ~clk;

    adc_capture_if #(.ADC_WIDTH(14)) ia ();
    adc_capture_if #(.ADC_WIDTH(14)) ip ();

    adc_capture #(.ADC_WIDTH(14), .DECIM_LOG2(2), .SETTLE_SAMPLES(8), .CNT_WIDTH(16)) u_avg (
        .clk(clk), .rst_n(rst_a), .enable(en_a), .clr_stat(clr_a), .bus(ia),
        .busy(busy_a), .overflow(ov_a), .drop_cnt(dc_a)
    );

    adc_capture #(.ADC_WIDTH(14), .DECIM_LOG2(0), .SETTLE_SAMPLES(0), .CNT_WIDTH(16)) u_pt (
        .clk(clk), .rst_n(rst_p), .enable(en_p), .clr_stat(clr_p), .bus(ip),
        .busy(busy_p), .overflow(ov_p), .drop_cnt(dc_p)
    );

    typedef struct {
        logic        v;
        logic [13:0] d;
        logic        f;
        logic        c;
        logic        wr;
        logic [13:0] wd;
        logic        ov;
        logic [15:0] dc;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(input logic v, input int d, input logic f, input logic c,
                                input logic wr, input int wd, input logic ov, input int dc);
        vec_t r;
        r.v = v; r.d = 14'(d); r.f = f; r.c = c;
        r.wr = wr; r.wd = 14'(wd); r.ov = ov; r.dc = 16'(dc);
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc_a(input logic v, input logic [13:0] d, input logic f, input logic c);
        ia.adc_valid = v; ia.adc_data = d; ia.fifo_full = f; clr_a = c;
        @(posedge clk); #1;
    endtask

    task automatic cyc_p(input logic v, input logic [13:0] d, input logic f, input logic c);
        ip.adc_valid = v; ip.adc_data = d; ip.fifo_full = f; clr_p = c;
        @(posedge clk); #1;
    endtask

    task automatic reset_a();
        rst_a = 1'b0; en_a = 1'b0;
        cyc_a(0, 0, 0, 0);
        rst_a = 1'b1;
    endtask

    initial begin
        logic [13:0] gd[16];
        logic [13:0] pv[4];
        gd = '{0, 1, 2, 3, 4, 5, 6, 7, 100, 101, 102, 103, 200, 200, 200, 201};
        pv = '{14'h3FFF, 0, 14'h1234, 5};
        rst_a = 1'b0; rst_p = 1'b0; en_a = 1'b0; en_p = 1'b0; clr_a = 1'b0; clr_p = 1'b0;
        ia.adc_valid = 1'b0; ia.adc_data = '0; ia.fifo_full = 1'b0;
        ip.adc_valid = 1'b0; ip.adc_data = '0; ip.fifo_full = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset wr_en", ia.wr_en, 0);
        chk("reset wr_data", ia.wr_data, 0);
        chk("reset busy", busy_a, 0);
        chk("reset overflow", ov_a, 0);
        chk("reset drop_cnt", dc_a, 0);

        for (int i = 0; i < 8; i++) tv.push_back(mk(1, i, 0, 0, 0, 0, 0, 0));
        tv.push_back(mk(1, 100, 0, 0, 0, 0, 0, 0));
        tv.push_back(mk(1, 101, 0, 0, 0, 0, 0, 0));
        tv.push_back(mk(1, 102, 0, 0, 0, 0, 0, 0));
        tv.push_back(mk(1, 103, 0, 0, 1, 101, 0, 0));
        for (int i = 0; i < 3; i++) tv.push_back(mk(1, 200, 0, 0, 0, 101, 0, 0));
        tv.push_back(mk(1, 201, 0, 0, 1, 200, 0, 0));
        for (int b = 0; b < 3; b++) begin
            for (int i = 0; i < 3; i++) tv.push_back(mk(1, 7, 1, 0, 0, 200, b > 0, b));
            tv.push_back(mk(1, 7, 1, 0, 0, 200, 1, b + 1));
        end
        tv.push_back(mk(0, 0, 0, 0, 0, 200, 1, 3));
        tv.push_back(mk(1, 4, 0, 0, 0, 200, 1, 3));
        tv.push_back(mk(1, 8, 0, 0, 0, 200, 1, 3));
        tv.push_back(mk(1, 12, 0, 0, 0, 200, 1, 3));
        tv.push_back(mk(1, 16, 0, 0, 1, 10, 1, 3));
        for (int i = 0; i < 3; i++) tv.push_back(mk(1, 1, 1, 0, 0, 10, 1, 3));
        tv.push_back(mk(1, 1, 1, 1, 0, 10, 1, 1));
        tv.push_back(mk(0, 0, 0, 1, 0, 10, 0, 0));
        tv.push_back(mk(0, 0, 1, 0, 0, 10, 0, 0));

        rst_a = 1'b1; en_a = 1'b1;
        cyc_a(0, 0, 0, 0);
        chk("enable busy", busy_a, 1);
        foreach (tv[i]) begin
            cyc_a(tv[i].v, tv[i].d, tv[i].f, tv[i].c);
            chk($sformatf("vec[%0d] wr_en", i), ia.wr_en, tv[i].wr);
            chk($sformatf("vec[%0d] wr_data", i), ia.wr_data, tv[i].wd);
            chk($sformatf("vec[%0d] overflow", i), ov_a, tv[i].ov);
            chk($sformatf("vec[%0d] drop_cnt", i), dc_a, tv[i].dc);
            chk($sformatf("vec[%0d] busy", i), busy_a, 1);
        end

        // gapped valid: one sample every third cycle
        reset_a();
        en_a = 1'b1;
        cyc_a(0, 0, 0, 0);
        wr_seen = 0;
        for (int i = 0; i < 16; i++) begin
            cyc_a(1, gd[i], 0, 0);
            wr_seen += int'(ia.wr_en);
            if (i == 11) chk("gap word0", ia.wr_data, 101);
            if (i == 15) chk("gap word1", ia.wr_data, 200);
            chk($sformatf("gap[%0d] wr_en", i), ia.wr_en, i == 11 || i == 15);
            for (int g = 0; g < 2; g++) begin
                cyc_a(0, 0, 0, 0);
                wr_seen += int'(ia.wr_en);
            end
        end
        chk("gap write count", wr_seen, 2);

        // abort mid-block, then re-enable must settle again
        reset_a();
        en_a = 1'b1;
        cyc_a(0, 0, 0, 0);
        for (int i = 0; i < 8; i++) cyc_a(1, 14'(i), 0, 0);
        cyc_a(1, 100, 0, 0);
        cyc_a(1, 100, 0, 0);
        en_a = 1'b0;
        cyc_a(0, 0, 0, 0);
        chk("abort busy", busy_a, 0);
        chk("abort wr_en", ia.wr_en, 0);
        en_a = 1'b1;
        cyc_a(0, 0, 0, 0);
        wr_seen = 0;
        for (int i = 0; i < 8; i++) begin
            cyc_a(1, 1000, 0, 0);
            wr_seen += int'(ia.wr_en);
        end
        for (int i = 0; i < 3; i++) begin
            cyc_a(1, 50, 0, 0);
            wr_seen += int'(ia.wr_en);
        end
        chk("resettle no write", wr_seen, 0);
        cyc_a(1, 54, 0, 0);
        chk("resettle wr_en", ia.wr_en, 1);
        chk("resettle wr_data", ia.wr_data, 51);
        for (int i = 0; i < 3; i++) cyc_a(1, 60, 0, 0);
        en_a = 1'b0;
        cyc_a(1, 64, 0, 0);
        chk("falling enable wr_en", ia.wr_en, 1);
        chk("falling enable wr_data", ia.wr_data, 61);
        chk("falling enable busy", busy_a, 0);
        cyc_a(0, 0, 0, 0);
        chk("after falling wr_en", ia.wr_en, 0);

        // pass-through instance
        rst_p = 1'b1; en_p = 1'b1;
        cyc_p(0, 0, 0, 0);
        chk("pt busy", busy_p, 1);
        foreach (pv[i]) begin
            cyc_p(1, pv[i], 0, 0);
            chk($sformatf("pt[%0d] wr_en", i), ip.wr_en, 1);
            chk($sformatf("pt[%0d] wr_data", i), ip.wr_data, pv[i]);
        end
        cyc_p(0, 0, 0, 0);
        chk("pt idle wr_en", ip.wr_en, 0);
        chk("pt hold wr_data", ip.wr_data, 5);
        cyc_p(1, 14'h111, 1, 0);
        chk("pt drop wr_en", ip.wr_en, 0);
        chk("pt drop overflow", ov_p, 1);
        chk("pt drop cnt", dc_p, 1);
        cyc_p(1, 14'h222, 0, 0);
        chk("pt pre-reset wr_en", ip.wr_en, 1);
        #2 rst_p = 1'b0;
        #1;
        chk("async rst wr_en", ip.wr_en, 0);
        chk("async rst busy", busy_p, 0);
        chk("async rst overflow", ov_p, 0);
        chk("async rst drop_cnt", dc_p, 0);
        chk("async rst wr_data", ip.wr_data, 0);
        @(posedge clk); #1;
        rst_p = 1'b1;

        // saturate the drop counter
        cyc_p(0, 0, 0, 0);
        ip.adc_valid = 1'b1; ip.fifo_full = 1'b1; ip.adc_data = 14'h55;
        repeat (70000) @(posedge clk);
        #1;
        chk("sat drop_cnt", dc_p, 16'hFFFF);
        chk("sat overflow", ov_p, 1);
        chk("sat wr_en", ip.wr_en, 0);
        cyc_p(0, 0, 0, 1);
        chk("sat clear drop_cnt", dc_p, 0);
        chk("sat clear overflow", ov_p, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
